// File: rtl/mul32_seq_ctrl.sv
// Unsigned 32x32->64 multiplier sequencer that time-shares one external 8x8 multiplier.
// Sixteen byte-pair products are issued one per cycle; a tag pipeline carries each product's weight to the accumulator.
module mul32_seq_ctrl #(
    parameter int MUL_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        abort,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_product,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] shift;
    } tag_t;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  k_q, k_d;
    logic [2:0]  drain_q, drain_d;
    logic [7:0]  mul_a_q, mul_a_d;
    logic [7:0]  mul_b_q, mul_b_d;
    logic [63:0] acc_q, acc_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_product_q, out_product_d;

    // tag_q[0] travels with the registered mul_a/mul_b; tag_q[MUL_LATENCY] lines up with mul_p.
    tag_t tag_q [MUL_LATENCY+1];
    tag_t tag_d [MUL_LATENCY+1];

    tag_t tag_out;
    logic accept;

    assign in_ready = (state_q == IDLE) && !abort;
    assign accept   = in_valid && in_ready;
    assign tag_out  = tag_q[MUL_LATENCY];

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        k_d           = k_q;
        drain_d       = drain_q;
        mul_a_d       = 8'h00;
        mul_b_d       = 8'h00;
        acc_d         = acc_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;

        tag_d[0] = '0;
        for (int i = 1; i <= MUL_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (tag_out.valid) begin
            acc_d = acc_q + ({48'h0, mul_p} << {tag_out.shift, 3'b000});
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_a_d        = a_q[{k_q[1:0], 3'b000} +: 8];
                mul_b_d        = b_q[{k_q[3:2], 3'b000} +: 8];
                tag_d[0].valid = 1'b1;
                tag_d[0].shift = {1'b0, k_q[1:0]} + {1'b0, k_q[3:2]};
                k_d            = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    if (MUL_LATENCY > 0) begin
                        drain_d = 3'(MUL_LATENCY - 1);
                        state_d = DRAIN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            DONE: begin
                // First DONE cycle still absorbs the last returning product, so the result is captured from acc_d.
                if (!out_valid_q) begin
                    out_valid_d   = 1'b1;
                    out_product_d = acc_d;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            k_d         = '0;
            mul_a_d     = 8'h00;
            mul_b_d     = 8'h00;
            for (int i = 0; i <= MUL_LATENCY; i++) begin
                tag_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            k_q           <= '0;
            drain_q       <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            acc_q         <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            tag_q         <= '{default: '0};
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            k_q           <= k_d;
            drain_q       <= drain_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            acc_q         <= acc_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            tag_q         <= tag_d;
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench: three instances (multiplier latency 0, 3, 4) share one stimulus stream, each with its own 8x8 model.
module tb_mul32_seq_ctrl;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;

    logic        in_ready_w    [N];
    logic [7:0]  mul_a_w       [N];
    logic [7:0]  mul_b_w       [N];
    logic [15:0] mul_p_w       [N];
    logic        out_valid_w   [N];
    logic [63:0] out_product_w [N];
    logic        busy_w        [N];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 4);
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 3 : 4);
        if (L == 0) begin : g_comb
            assign mul_p_w[g] = {8'h00, mul_a_w[g]} * {8'h00, mul_b_w[g]};
        end else begin : g_pipe
            logic [15:0] pipe [L] = '{default: '0};
            always @(posedge clk) begin
                pipe[0] <= {8'h00, mul_a_w[g]} * {8'h00, mul_b_w[g]};
                for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            end
            assign mul_p_w[g] = pipe[L-1];
        end

        mul32_seq_ctrl #(.MUL_LATENCY(L)) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .in_valid    (in_valid),
            .in_ready    (in_ready_w[g]),
            .in_a        (in_a),
            .in_b        (in_b),
            .abort       (abort),
            .mul_a       (mul_a_w[g]),
            .mul_b       (mul_b_w[g]),
            .mul_p       (mul_p_w[g]),
            .out_valid   (out_valid_w[g]),
            .out_ready   (out_ready),
            .out_product (out_product_w[g]),
            .busy        (busy_w[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (!(in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 60) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic hold, input string name);
        wait_idle();
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = !hold;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        for (int i = 0; i < N; i++) check($sformatf("%s_busy%0d", name, i), 64'(busy_w[i]), 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                          input logic hold, input logic seq, input string name);
        int          seen [N];
        logic [63:0] prod [N];
        accept_op(a, b, hold, name);
        for (int i = 0; i < N; i++) begin
            seen[i] = -1;
            prod[i] = '0;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (seq && c <= 16) begin
                check($sformatf("%s_mul_a_k%0d", name, c-1), 64'(mul_a_w[0]), 64'(a[8*((c-1)%4) +: 8]));
                check($sformatf("%s_mul_b_k%0d", name, c-1), 64'(mul_b_w[0]), 64'(b[8*((c-1)/4) +: 8]));
            end
            for (int i = 1; i < N; i++) begin
                if (c > 16 && c <= 16 + lat_of(i)) begin
                    check($sformatf("%s_drain_mul_a%0d_c%0d", name, i, c), 64'(mul_a_w[i]), 64'd0);
                    check($sformatf("%s_drain_mul_b%0d_c%0d", name, i, c), 64'(mul_b_w[i]), 64'd0);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (seen[i] < 0 && out_valid_w[i]) begin
                    seen[i] = c;
                    prod[i] = out_product_w[i];
                end
            end
            if (seen[0] >= 0 && seen[1] >= 0 && seen[2] >= 0) break;
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_latency%0d", name, i), 64'(seen[i]), 64'(17 + lat_of(i)));
            check($sformatf("%s_product%0d", name, i), prod[i], exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bp_exp;

        #22;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_in_ready%0d", i), 64'(in_ready_w[i]), 64'd1);
            check($sformatf("rst_out_valid%0d", i), 64'(out_valid_w[i]), 64'd0);
            check($sformatf("rst_product%0d", i), out_product_w[i], 64'd0);
            check($sformatf("rst_busy%0d", i), 64'(busy_w[i]), 64'd0);
            check($sformatf("rst_mul_a%0d", i), 64'(mul_a_w[i]), 64'd0);
            check($sformatf("rst_mul_b%0d", i), 64'(mul_b_w[i]), 64'd0);
        end
        @(negedge clk);
        rstn = 1'b1;

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, "max32");
        run_op(32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1'b0, 1'b0, "max16");
        run_op(32'h0403_0201, 32'h8070_6050, 64'(32'h0403_0201) * 64'(32'h8070_6050), 1'b0, 1'b1, "order");
        run_op(32'h0000_0100, 32'h0001_0000, 64'h0000_0000_0100_0000, 1'b0, 1'b0, "shift_mid");
        run_op(32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b0, 1'b0, "shift_top");

        // Back-pressure: hold out_ready low and confirm everything freezes.
        bp_exp = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, bp_exp, 1'b1, 1'b0, "bp");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                check($sformatf("bp_hold_valid%0d_c%0d", i, c), 64'(out_valid_w[i]), 64'd1);
                check($sformatf("bp_hold_product%0d_c%0d", i, c), out_product_w[i], bp_exp);
                check($sformatf("bp_hold_in_ready%0d_c%0d", i, c), 64'(in_ready_w[i]), 64'd0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("bp_release_valid%0d", i), 64'(out_valid_w[i]), 64'd0);
            check($sformatf("bp_release_busy%0d", i), 64'(busy_w[i]), 64'd0);
            check($sformatf("bp_release_product%0d", i), out_product_w[i], bp_exp);
        end
        run_op(32'h3, 32'h5, 64'hF, 1'b0, 1'b0, "b2b");

        // Abort in ISSUE at k=7, then a clean operation.
        accept_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, "abort_op");
        repeat (7) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        for (int i = 0; i < N; i++) check($sformatf("abort_in_ready%0d", i), 64'(in_ready_w[i]), 64'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("abort_busy%0d", i), 64'(busy_w[i]), 64'd0);
            check($sformatf("abort_valid%0d", i), 64'(out_valid_w[i]), 64'd0);
        end
        run_op(32'h2, 32'h3, 64'h6, 1'b0, 1'b0, "after_abort");

        // Reset pulse while the latency-4 instance is draining.
        accept_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "rst_op");
        repeat (18) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("midrst_busy%0d", i), 64'(busy_w[i]), 64'd0);
            check($sformatf("midrst_valid%0d", i), 64'(out_valid_w[i]), 64'd0);
            check($sformatf("midrst_mul_a%0d", i), 64'(mul_a_w[i]), 64'd0);
            check($sformatf("midrst_in_ready%0d", i), 64'(in_ready_w[i]), 64'd1);
        end
        @(negedge clk);
        rstn = 1'b1;
        run_op(32'h2, 32'h3, 64'h6, 1'b0, 1'b0, "after_reset");

        // Abort together with in_valid while idle: nothing is accepted.
        wait_idle();
        @(negedge clk);
        in_a     = 32'h7;
        in_b     = 32'h9;
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        for (int i = 0; i < N; i++) check($sformatf("idle_abort_in_ready%0d", i), 64'(in_ready_w[i]), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        for (int i = 0; i < N; i++) check($sformatf("idle_abort_busy%0d", i), 64'(busy_w[i]), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) check($sformatf("idle_abort_still_idle%0d", i), 64'(busy_w[i]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
